// File: rtl/as_dmem_hs_pkg.sv
// Shared types and helpers for the as_dmem_hs data memory.
// Holds the access-size enum, the FSM state enum, default geometry
// constants and the small decode/extend helpers used by top and lane.
package as_pack;

  localparam int XLEN_DEF  = 64;
  localparam int DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Number of bytes touched by an access, minus one.
  function automatic logic [3:0] size_bytes_m1(input size_e sz);
    logic [3:0] n;
    case (sz)
      SZ_BYTE: n = 4'd0;
      SZ_HALF: n = 4'd1;
      SZ_WORD: n = 4'd3;
      default: n = 4'd7;
    endcase
    return n;
  endfunction

  // Byte-enable pattern of an access placed at offset zero.
  function automatic logic [7:0] size_byte_mask(input size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Sign- or zero-extend an LSB-aligned load value to 64 bits.
  function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                              input size_e sz,
                                              input logic uns);
    logic [63:0] r;
    case (sz)
      SZ_BYTE: r = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_HALF: r = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_WORD: r = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/as_dmem_lane.sv
// Combinational byte-enable / write-data shifter for one beat.
// The access is placed in a two-word window at its byte offset; BEAT
// selects which half of that window (first or second word) this
// instance produces.
module as_dmem_lane
  import as_pack::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter bit BEAT = 1'b0
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [1:0]                size_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o
);

  localparam int NB = XLEN / 8;

  logic [2*NB-1:0]   mask_base;
  logic [2*NB-1:0]   mask_win;
  logic [2*XLEN-1:0] data_win;

  // Shift the enable mask and the store data to the access offset.
  always_comb begin
    mask_base      = '0;
    mask_base[7:0] = size_byte_mask(size_e'(size_i));
    mask_win       = mask_base << off_i;
    data_win       = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
  end

  assign be_o    = BEAT ? mask_win[2*NB-1:NB]       : mask_win[NB-1:0];
  assign wdata_o = BEAT ? data_win[2*XLEN-1:XLEN]   : data_win[XLEN-1:0];

endmodule

// File: rtl/as_dmem_hs.sv
// Valid/ready data memory with byte/half/word/double loads and stores.
// Non-crossing accesses respond one cycle after acceptance. When the
// macro AS_DMEM_MISALIGN_EN is defined, accesses spanning two words are
// split into two beats (IDLE->BEAT1->RESP); otherwise any misaligned
// access is answered with an error and BEAT1 is never entered.
module as_dmem_hs
  import as_pack::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * NB);

  state_e            state_q, state_d;
  logic              we_q, uns_q, err_q, cross_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [IDX_W-1:0]  idx_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata0_q;

  logic              accept;
  logic [3:0]        nbm1;
  logic [ADDR_W:0]   last_byte;
  logic [OFF_W-1:0]  off_in;
  logic [IDX_W-1:0]  idx_in;
  logic              cross_in, err_in;

  logic [NB-1:0]     be0, be1;
  logic [XLEN-1:0]   wd0, wd1;

  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   rd_q;
  logic              ram_en;
  logic [IDX_W-1:0]  ram_idx;
  logic [NB-1:0]     ram_be;
  logic [XLEN-1:0]   ram_wdata;

  logic [2*XLEN-1:0] rd_win;
  logic [XLEN-1:0]   rd_raw;
  logic [63:0]       rd_ext;

  assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

`ifdef AS_DMEM_MISALIGN_EN
  logic [OFF_W+1:0]  last_off;
`else
  logic              misalign;
`endif

  // Decode the incoming request: word index, offset, crossing and error.
  always_comb begin
    nbm1      = size_bytes_m1(size_e'(req_size_i));
    off_in    = req_addr_i[OFF_W-1:0];
    idx_in    = req_addr_i[OFF_W +: IDX_W];
    last_byte = {1'b0, req_addr_i} + (ADDR_W+1)'(nbm1);
    err_in    = ((XLEN == 32) && (req_size_i == 2'd3)) || (last_byte >= MEM_BYTES);
`ifdef AS_DMEM_MISALIGN_EN
    last_off  = (OFF_W+2)'(off_in) + (OFF_W+2)'(nbm1);
    cross_in  = (last_off >= (OFF_W+2)'(NB));
`else
    misalign  = (req_addr_i[2:0] & nbm1[2:0]) != 3'b000;
    cross_in  = 1'b0;
    err_in    = err_in || misalign;
`endif
  end

  // First beat works on the live request, second beat on the captured one.
  as_dmem_lane #(.XLEN(XLEN), .BEAT(1'b0)) u_lane0 (
    .off_i   (off_in),
    .size_i  (req_size_i),
    .wdata_i (req_wdata_i),
    .be_o    (be0),
    .wdata_o (wd0)
  );

  as_dmem_lane #(.XLEN(XLEN), .BEAT(1'b1)) u_lane1 (
    .off_i   (off_q),
    .size_i  (size_q),
    .wdata_i (wdata_q),
    .be_o    (be1),
    .wdata_o (wd1)
  );

  // Next-state logic of the request/response FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (cross_in && !err_in) ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: state_d = ST_RESP;
      ST_RESP: begin
        if (accept)           state_d = (cross_in && !err_in) ? ST_BEAT1 : ST_RESP;
        else if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and captured request fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      cross_q  <= 1'b0;
      size_q   <= 2'd0;
      off_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= err_in;
        cross_q <= cross_in && !err_in;
        size_q  <= req_size_i;
        off_q   <= off_in;
        idx_q   <= idx_in;
        wdata_q <= req_wdata_i;
      end
      if (state_q == ST_BEAT1) rdata0_q <= rd_q;
    end
  end

  // Memory port steering: second beat targets the following word.
  always_comb begin
    ram_en = accept || (state_q == ST_BEAT1);
    if (state_q == ST_BEAT1) begin
      ram_idx   = idx_q + IDX_W'(1);
      ram_be    = we_q ? be1 : '0;
      ram_wdata = wd1;
    end else begin
      ram_idx   = idx_in;
      ram_be    = (accept && req_we_i && !err_in) ? be0 : '0;
      ram_wdata = wd0;
    end
  end

  // Byte-lane write, registered read; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      for (int b = 0; b < NB; b++) begin
        if (ram_be[b]) mem_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      rd_q <= mem_q[ram_idx];
    end
  end

  // Align the (one or two) read words to the access offset and extend.
  always_comb begin
    rd_win = cross_q ? {rd_q, rdata0_q} : {{XLEN{1'b0}}, rd_q};
    rd_raw = XLEN'(rd_win >> {off_q, 3'b000});
    rd_ext = load_extend(64'(rd_raw), size_e'(size_q), uns_q);
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o = ((state_q == ST_RESP) && !we_q && !err_q) ? XLEN'(rd_ext) : '0;

endmodule

// File: tb/tb_as_dmem_hs.sv
// Directed self-checking bench for as_dmem_hs (XLEN=64, DEPTH=512).
// Expectations follow AS_DMEM_MISALIGN_EN when it is defined.
module tb_as_dmem_hs;

  localparam int XLEN   = 64;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'd0;
  logic              req_uns = 1'b0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  as_dmem_hs #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready held high; latency counted in cycles.
  task automatic txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] sz,
                     input logic uns, input logic [63:0] wd,
                     output logic [63:0] rdata, output logic err, output int lt);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
    req_uns = uns; req_wdata = wd; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    lt = 1;
    while (!rsp_valid && lt < 20) begin @(negedge clk); lt++; end
    chk("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    $display("txn we=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, addr, sz, uns, wd, rdata, err, lt);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_err",   {63'd0, rsp_err},   64'd0);
    chk("rst_rdata", rsp_rdata,          64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);

    // Double store/load
    txn(1'b1, 12'h010, 2'd3, 1'b0, 64'h1122334455667788, rd, er, lat);
    chk("st_d_err", {63'd0, er}, 64'd0);
    chk("st_d_rdata", rd, 64'd0);
    chk("st_d_lat", 64'(lat), 64'd1);
    chk("resp_ready_b2b", {63'd0, req_ready}, 64'd1);
    txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("ld_d", rd, 64'h1122334455667788);
    chk("ld_d_lat", 64'(lat), 64'd1);

    // Byte store, signed/unsigned byte load, neighbours intact
    txn(1'b1, 12'h013, 2'd0, 1'b0, 64'h0000000000000080, rd, er, lat);
    txn(1'b0, 12'h013, 2'd0, 1'b0, 64'd0, rd, er, lat);
    chk("ld_b_s", rd, 64'hFFFFFFFFFFFFFF80);
    txn(1'b0, 12'h013, 2'd0, 1'b1, 64'd0, rd, er, lat);
    chk("ld_b_u", rd, 64'h0000000000000080);
    txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("ld_d_after_b", rd, 64'h1122334480667788);

    // Half and word lanes
    txn(1'b1, 12'h040, 2'd3, 1'b0, 64'd0, rd, er, lat);
    txn(1'b1, 12'h042, 2'd1, 1'b0, 64'h0000000000008001, rd, er, lat);
    txn(1'b0, 12'h040, 2'd2, 1'b0, 64'd0, rd, er, lat);
    chk("ld_w_s", rd, 64'hFFFFFFFF80010000);
    txn(1'b0, 12'h042, 2'd1, 1'b1, 64'd0, rd, er, lat);
    chk("ld_h_u", rd, 64'h0000000000008001);
    txn(1'b1, 12'h048, 2'd3, 1'b0, 64'd0, rd, er, lat);
    txn(1'b1, 12'h048, 2'd2, 1'b0, 64'hAAAAAAAACAFEF00D, rd, er, lat);
    txn(1'b0, 12'h048, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("st_w_lanes", rd, 64'h00000000CAFEF00D);
    txn(1'b0, 12'h048, 2'd2, 1'b0, 64'd0, rd, er, lat);
    chk("ld_w_s2", rd, 64'hFFFFFFFFCAFEF00D);

    // Word store at 0x01E spanning two words
    txn(1'b1, 12'h018, 2'd3, 1'b0, 64'h0706050403020100, rd, er, lat);
    txn(1'b1, 12'h020, 2'd3, 1'b0, 64'h0F0E0D0C0B0A0908, rd, er, lat);
    txn(1'b1, 12'h01E, 2'd2, 1'b0, 64'h00000000DEADBEEF, rd, er, lat);
`ifdef AS_DMEM_MISALIGN_EN
    chk("x_st_err", {63'd0, er}, 64'd0);
    chk("x_st_lat", 64'(lat), 64'd2);
    txn(1'b0, 12'h01E, 2'd2, 1'b1, 64'd0, rd, er, lat);
    chk("x_ld_u", rd, 64'h00000000DEADBEEF);
    chk("x_ld_lat", 64'(lat), 64'd2);
    txn(1'b0, 12'h01E, 2'd2, 1'b0, 64'd0, rd, er, lat);
    chk("x_ld_s", rd, 64'hFFFFFFFFDEADBEEF);
    txn(1'b0, 12'h018, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("x_word0", rd, 64'hBEEF050403020100);
    txn(1'b0, 12'h020, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("x_word1", rd, 64'h0F0E0D0C0B0ADEAD);
`else
    chk("mis_st_err", {63'd0, er}, 64'd1);
    chk("mis_st_lat", 64'(lat), 64'd1);
    txn(1'b0, 12'h01E, 2'd2, 1'b1, 64'd0, rd, er, lat);
    chk("mis_ld_err", {63'd0, er}, 64'd1);
    chk("mis_ld_rdata", rd, 64'd0);
    txn(1'b0, 12'h018, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mis_word0", rd, 64'h0706050403020100);
    txn(1'b0, 12'h020, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mis_word1", rd, 64'h0F0E0D0C0B0A0908);
`endif

    // Out-of-range accesses
    txn(1'b0, 12'hFFC, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("oor_err", {63'd0, er}, 64'd1);
    chk("oor_rdata", rd, 64'd0);
    txn(1'b1, 12'hFF8, 2'd3, 1'b0, 64'hA5A5A5A5A5A5A5A5, rd, er, lat);
    chk("last_st_err", {63'd0, er}, 64'd0);
    txn(1'b1, 12'hFFF, 2'd1, 1'b0, 64'h0000000000001234, rd, er, lat);
    chk("wrap_st_err", {63'd0, er}, 64'd1);
    txn(1'b0, 12'hFF8, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("wrap_no_write", rd, 64'hA5A5A5A5A5A5A5A5);

    // Backpressure: response held, new request ignored while not ready
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010;
    req_size = 2'd3; req_uns = 1'b0; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 64'd0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_rdata", rsp_rdata, 64'h1122334480667788);
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    $display("txn backpressure load addr=010 held 3 cycles rdata=%h", rsp_rdata);
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1 chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    chk("bp_done_valid", {63'd0, rsp_valid}, 64'd0);
    txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("bp_no_write", rd, 64'h1122334480667788);

    // Reset in the middle of an access
    @(negedge clk);
`ifdef AS_DMEM_MISALIGN_EN
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h01E; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("beat1_no_valid", {63'd0, rsp_valid}, 64'd0);
`else
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_size = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid_pre_rst", {63'd0, rsp_valid}, 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_rdata", rsp_rdata, 64'd0);
    $display("txn reset asserted mid-access valid=%0d ready=%0d", rsp_valid, req_ready);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {63'd0, rsp_valid}, 64'd0);
    txn(1'b0, 12'h010, 2'd3, 1'b0, 64'd0, rd, er, lat);
    chk("mem_kept", rd, 64'h1122334480667788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/as_dmem_hs.md
AS_DMEM_HS -- requirements
Module: as_dmem_hs

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 512, memory depth in XLEN-bit words; power of two.
REQ-003 SHALL have parameter ADDR_W, default 12, byte-address width; ADDR_W >= log2(DEPTH*XLEN/8).
REQ-004 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid_i  in  1  request valid; req_ready_o  out  1  request accepted when both high.
REQ-007 SHALL have ports: req_we_i  in  1  store=1/load=0; req_addr_i  in  ADDR_W  byte address.
REQ-008 SHALL have ports: req_size_i  in  2  0=byte,1=half,2=word,3=double; req_unsigned_i  in  1  zero-extend load.
REQ-009 SHALL have ports: req_wdata_i  in  XLEN  store data, LSB-aligned.
REQ-010 SHALL have ports: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_rdata_o  out  XLEN; rsp_err_o  out  1.

Function
REQ-011 SHALL run FSM states IDLE, BEAT1, RESP.
REQ-012 SHALL assert req_ready_o in IDLE, and in RESP when rsp_ready_i is high the same cycle, enabling back-to-back accepts.
REQ-013 SHALL take a non-crossing access from accept to RESP in one cycle, so rsp_valid_o rises on the edge after acceptance.
REQ-014 SHALL treat an access whose bytes span two XLEN words as crossing; it SHALL go IDLE->BEAT1->RESP, with a latency of 2 cycles.
REQ-015 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i is high, then return to IDLE or accept a new request.
REQ-016 SHALL store bytes little-endian, writing only the enabled byte lanes and leaving the other lanes unchanged.
REQ-017 SHALL sign-extend loads from bit 8*2^size-1 unless req_unsigned_i is set, in which case it zero-extends.
REQ-018 SHALL return rsp_rdata_o=0 for stores and for errored accesses.
REQ-019 SHALL flag an error (rsp_err_o=1, no memory write) when size=3 with XLEN=32, or when any addressed byte is at or beyond DEPTH*XLEN/8.
REQ-020 SHALL ignore req_valid_i while req_ready_o is low, and the requester SHALL hold its request stable until accepted.
REQ-021 SHALL, when a crossing store wraps past the last word, flag an error and write nothing; a partial write is forbidden.

Reset
REQ-022 SHALL, on rst_ni low, go to IDLE immediately and set rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1 once released.
REQ-023 SHALL abandon an in-flight access if reset occurs mid-operation; a first-beat store may persist, no response is issued; memory contents are not reset.

Configuration
REQ-024 SHALL support macro AS_DMEM_MISALIGN_EN.
REQ-025 SHALL, with AS_DMEM_MISALIGN_EN defined, split crossing accesses per REQ-014.
REQ-026 SHALL, without AS_DMEM_MISALIGN_EN, treat any access not naturally aligned to its size as an error (REQ-019 response, latency 1, no write); BEAT1 is unreachable.

Structure
REQ-027 SHALL place the size enum, the FSM state enum and the default XLEN/DEPTH constants in shared package as_pack.
REQ-028 SHALL use one sub-module, as_dmem_lane: combinational byte-enable/shift generator, with one instance per beat.

Verification
REQ-029 SHALL pass this scenario with XLEN=64: store double 0x1122334455667788 @0x010, then load double @0x010 -> rsp_rdata_o=0x1122334455667788, 1-cycle latency.
REQ-030 SHALL pass this scenario: store byte 0x80 @0x013, load byte signed @0x013 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; the other bytes of word 0x010 are unchanged.
REQ-031 SHALL pass this scenario with MISALIGN_EN: store word 0xDEADBEEF @0x01E, load word unsigned @0x01E -> 0xDEADBEEF, latency 2, both words touched.
REQ-032 SHALL pass this scenario without MISALIGN_EN: same store @0x01E -> rsp_err_o=1, memory unchanged, latency 1.
REQ-033 SHALL pass this scenario with DEPTH=512: load double @0xFFC -> rsp_err_o=1, rsp_rdata_o=0.
REQ-034 SHALL pass this scenario: hold rsp_ready_i low 3 cycles -> response stable and req_ready_o=0; drop rst_ni during BEAT1 -> IDLE, rsp_valid_o=0.
